// File: rtl/fifo_param_pkg.sv
// Shared defaults for the FIFO family: word width, depth, pointer and threshold widths.
// Also defines the per-cycle operation encoding used by the occupancy bookkeeping.
package fifo_param_pkg;

  localparam int FIFO_DATA_W_DEF = 6;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int FIFO_ADDR_W_DEF = 3;
  localparam int FIFO_THR_W_DEF  = FIFO_ADDR_W_DEF + 1;

  // Bit 1 = write accepted, bit 0 = read accepted.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W dual-port storage: synchronous write, registered read.
// Array contents are never reset; only the read register clears on reset.
module fifo_mem_dp
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read samples the array before this edge's write lands, so a same-address
  // read/write (full FIFO, rd & wr together) returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with occupancy flags, hysteresis pause and sticky error.
// Read data appears one cycle after an accepted read; rejected ops only raise err_fifo.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [ADDR_W:0]   al_full_in,
  input  logic [ADDR_W:0]   al_empty_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              al_empty,
  output logic              al_full,
  output logic [ADDR_W:0]   count,
  output logic              pause,
  output logic              err_fifo
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              pause_q, pause_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  logic     rd_acc;
  logic     wr_acc;
  fifo_op_e op;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = fifo_rd && (count_q != '0);
  assign wr_acc = fifo_wr && ((count_q != FULL_CNT) || rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (op)
      OP_WR:   count_d = count_q + CNT_ONE;
      OP_RD:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Hysteresis on the post-edge occupancy; set beats clear when thresholds overlap.
  always_comb begin
    pause_d = pause_q;
    if (count_d >= al_full_in) begin
      pause_d = 1'b1;
    end else if (count_d <= al_empty_in) begin
      pause_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if ((fifo_wr && !wr_acc) || (fifo_rd && !rd_acc)) begin
      err_d = 1'b1;
    end
  end

  assign valid_d = rd_acc;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pause_q  <= pause_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .RESET_L (RESET_L),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign valid_out  = valid_q;
  assign count      = count_q;
  assign pause      = pause_q;
  assign err_fifo   = err_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign al_full    = (count_q >= al_full_in);
  assign al_empty   = (count_q <= al_empty_in);

endmodule

// File: tb/tb_fifo_param.sv
// Directed and random stimulus for fifo_param, checked against a queue-based reference model.
module tb_fifo_param;

  localparam int DW = 6;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          RESET_L;
  logic [DW-1:0] data_in;
  logic          fifo_wr, fifo_rd, err_clr;
  logic [AW:0]   al_full_in, al_empty_in;
  logic [DW-1:0] data_out;
  logic          valid_out, fifo_empty, fifo_full, al_empty, al_full, pause, err_fifo;
  logic [AW:0]   count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            mq[$];
  int            m_data = 0;
  bit            m_valid = 0, m_pause = 0, m_err = 0;

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .RESET_L(RESET_L), .data_in(data_in), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .al_full_in(al_full_in), .al_empty_in(al_empty_in), .err_clr(err_clr),
    .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .al_empty(al_empty), .al_full(al_full), .count(count), .pause(pause), .err_fifo(err_fifo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = mq.size();
    chk({ctx, ":count"},      32'(count), 32'(n));
    chk({ctx, ":empty"},      32'(fifo_empty), 32'(n == 0));
    chk({ctx, ":full"},       32'(fifo_full), 32'(n == DEPTH));
    chk({ctx, ":al_full"},    32'(al_full), 32'(n >= int'(al_full_in)));
    chk({ctx, ":al_empty"},   32'(al_empty), 32'(n <= int'(al_empty_in)));
    chk({ctx, ":valid_out"},  32'(valid_out), 32'(m_valid));
    chk({ctx, ":data_out"},   32'(data_out), 32'(m_data));
    chk({ctx, ":pause"},      32'(pause), 32'(m_pause));
    chk({ctx, ":err_fifo"},   32'(err_fifo), 32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = 0; m_valid = 0; m_pause = 0; m_err = 0;
  endtask

  // One clock: drive on the falling edge, predict, check 1ns after the rising edge.
  task automatic step(input bit wr, input bit rd, input int din, input bit clr, input string ctx);
    bit ra, wa;
    int n;
    @(negedge clk);
    fifo_wr = wr; fifo_rd = rd; data_in = DW'(din); err_clr = clr;
    ra = rd && (mq.size() > 0);
    wa = wr && (mq.size() < DEPTH || ra);
    if (clr) m_err = 0;
    if ((wr && !wa) || (rd && !ra)) m_err = 1;
    m_valid = ra;
    if (ra) m_data = mq.pop_front();
    if (wa) mq.push_back(din & ((1 << DW) - 1));
    n = mq.size();
    if (n >= int'(al_full_in)) m_pause = 1;
    else if (n <= int'(al_empty_in)) m_pause = 0;
    @(posedge clk);
    #1;
    fifo_wr = 0; fifo_rd = 0; err_clr = 0;
    check_all(ctx);
  endtask

  initial begin
    RESET_L = 1'b0;
    data_in = '0; fifo_wr = 0; fifo_rd = 0; err_clr = 0;
    al_full_in = 4'd6; al_empty_in = 4'd2;
    model_reset();
    #3;
    check_all("reset");
    al_empty_in = 4'd0;
    #1;
    chk("reset:al_empty_thr0", 32'(al_empty), 32'd1);
    al_empty_in = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET_L = 1'b1;

    // Fill with 0x01..0x08; pause rises when count reaches 6.
    for (int i = 1; i <= 8; i++) step(1, 0, i, 0, "fill");
    chk("fill:pause_at_full", 32'(pause), 32'd1);

    // Overflow: rejected write leaves contents intact.
    step(1, 0, 6'h3F, 0, "overflow");
    chk("overflow:err", 32'(err_fifo), 32'd1);
    step(0, 0, 0, 1, "err_clr");

    // Drain, then underflow.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, "drain");
    step(0, 1, 0, 0, "underflow");
    chk("underflow:valid", 32'(valid_out), 32'd0);
    // New error in the same cycle as clear wins.
    step(0, 1, 0, 1, "clr_vs_err");
    step(0, 0, 0, 1, "err_clr2");

    // count=1 with rd&wr returns the stored word.
    step(1, 0, 6'h11, 0, "one");
    step(1, 1, 6'h12, 0, "one_rdwr");
    chk("one_rdwr:data", 32'(data_out), 32'h11);
    for (int i = 0; i < 7; i++) step(1, 0, 6'h20 + i, 0, "refill");
    step(1, 1, 6'h2A, 0, "full_rdwr");
    chk("full_rdwr:data", 32'(data_out), 32'h12);

    // Threshold change takes effect combinationally.
    al_full_in = 4'd9; al_empty_in = 4'd8;
    #1;
    check_all("thr_change");
    al_full_in = 4'd5; al_empty_in = 4'd3;
    #1;
    check_all("thr_change2");

    // Random interleaved traffic across pointer wraps.
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) begin
        al_full_in  = 4'($urandom_range(3, 8));
        al_empty_in = 4'($urandom_range(0, 3));
      end
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           int'($urandom_range(0, 63)), $urandom_range(0, 9) == 0, "random");
    end

    // Reset mid-burst, observed without a clock edge.
    for (int i = 0; i < 4; i++) step(1, 0, 6'h30 + i, 0, "preburst");
    step(1, 1, 6'h35, 0, "preburst_rw");
    @(negedge clk);
    #2;
    RESET_L = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    RESET_L = 1'b1;
    step(1, 0, 6'h2A, 0, "post_wr");
    step(0, 1, 0, 0, "post_rd");
    chk("post_rd:data", 32'(data_out), 32'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
